// File: rtl/wb_result_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and non-blocking multiplier
// results onto one register-file write port, buffering multiplier results in a FIFO.
module wb_result_arbiter #(
  parameter int WD_SIZE       = 32,
  parameter int REG_ADDR_SIZE = 5,
  parameter int MUL_BUF_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               alu_valid_i,
  input  logic [REG_ADDR_SIZE-1:0]           alu_rd_i,
  input  logic [WD_SIZE-1:0]                 alu_data_i,
  output logic                               alu_ready_o,
  input  logic                               mul_valid_i,
  input  logic [REG_ADDR_SIZE-1:0]           mul_rd_i,
  input  logic [WD_SIZE-1:0]                 mul_data_i,
  output logic                               rf_we_o,
  output logic [REG_ADDR_SIZE-1:0]           rf_waddr_o,
  output logic [WD_SIZE-1:0]                 rf_wdata_o,
  output logic                               mul_pending_o,
  output logic [$clog2(MUL_BUF_DEPTH):0]     mul_count_o
);

  localparam int PTR_W = $clog2(MUL_BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MUL_BUF_DEPTH);

  logic [REG_ADDR_SIZE-1:0] buf_rd_reg   [MUL_BUF_DEPTH];
  logic [WD_SIZE-1:0]       buf_data_reg [MUL_BUF_DEPTH];
  logic [PTR_W-1:0]         head_reg;
  logic [PTR_W-1:0]         tail_reg;
  logic [CNT_W-1:0]         count_reg;
  logic [CNT_W-1:0]         count_next;

  logic                     we_reg;
  logic [REG_ADDR_SIZE-1:0] waddr_reg;
  logic [WD_SIZE-1:0]       wdata_reg;

  logic                     full;
  logic                     empty;
  logic                     mul_ok;
  logic                     push;
  logic                     pop;
  logic                     we_next;
  logic                     load_next;
  logic [REG_ADDR_SIZE-1:0] waddr_next;
  logic [WD_SIZE-1:0]       wdata_next;

  assign full   = (count_reg == CNT_FULL);
  assign empty  = (count_reg == '0);
  assign mul_ok = mul_valid_i && (mul_rd_i != '0);

  // Full forces a pop even over a valid ALU result; otherwise the ALU wins.
  assign pop  = full || (!alu_valid_i && !empty);
  assign push = mul_ok && (full || alu_valid_i || !empty);

  assign alu_ready_o   = !full;
  assign mul_pending_o = !empty;
  assign mul_count_o   = count_reg;
  assign rf_we_o       = we_reg;
  assign rf_waddr_o    = waddr_reg;
  assign rf_wdata_o    = wdata_reg;

  always_comb begin
    we_next    = 1'b0;
    load_next  = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    if (pop) begin
      // Entries are never x0, the input filter drops those before the push.
      we_next    = 1'b1;
      load_next  = 1'b1;
      waddr_next = buf_rd_reg[head_reg];
      wdata_next = buf_data_reg[head_reg];
    end else if (alu_valid_i) begin
      we_next    = (alu_rd_i != '0);
      load_next  = 1'b1;
      waddr_next = alu_rd_i;
      wdata_next = alu_data_i;
    end else if (mul_ok) begin
      we_next    = 1'b1;
      load_next  = 1'b1;
      waddr_next = mul_rd_i;
      wdata_next = mul_data_i;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      if (push) begin
        buf_rd_reg[tail_reg]   <= mul_rd_i;
        buf_data_reg[tail_reg] <= mul_data_i;
        tail_reg               <= tail_reg + PTR_ONE;
      end
      if (pop) begin
        head_reg <= head_reg + PTR_ONE;
      end
      count_reg <= count_next;
      we_reg    <= we_next;
      if (load_next) begin
        waddr_reg <= waddr_next;
        wdata_reg <= wdata_next;
      end
    end
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Self-checking bench for wb_result_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_wb_result_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic        mul_valid_i;
  logic [4:0]  mul_rd_i;
  logic [31:0] mul_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        mul_pending_o;
  logic [2:0]  mul_count_o;

  always #5 clk = ~clk;

  wb_result_arbiter #(.WD_SIZE(32), .REG_ADDR_SIZE(5), .MUL_BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .mul_valid_i(mul_valid_i), .mul_rd_i(mul_rd_i), .mul_data_i(mul_data_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .mul_pending_o(mul_pending_o), .mul_count_o(mul_count_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          cnt;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] sent_mul[$];
  logic [31:0] got_mul[$];
  logic        last_accept;
  logic        seen_not_ready;
  int          max_cnt;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle (called just after a rising edge), checks the combinational
  // status mid-cycle, advances the model and checks the registered write port.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    bit full, mul_ok, push;
    ent_t e;
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = adata;
    mul_valid_i = mv; mul_rd_i = mrd; mul_data_i = mdata;
    @(negedge clk);
    chk("alu_ready", 32'(alu_ready_o), 32'(mq.size() != DEPTH));
    chk("mul_pending", 32'(mul_pending_o), 32'(mq.size() != 0));
    chk("mul_count", 32'(mul_count_o), 32'(mq.size()));
    if (!alu_ready_o) seen_not_ready = 1'b1;
    full   = (mq.size() == DEPTH);
    mul_ok = mv && (mrd != 5'd0);
    push   = mul_ok && (full || av || mq.size() != 0);
    if (mul_ok && mdata[31:24] == 8'hB0) sent_mul.push_back(mdata);
    last_accept = av && !full;
    if (full || (!av && mq.size() != 0)) begin
      e = mq.pop_front();
      m_we = 1'b1; m_wa = e.rd; m_wd = e.d;
    end else if (av) begin
      m_we = (ard != 5'd0); m_wa = ard; m_wd = adata;
    end else if (mul_ok) begin
      m_we = 1'b1; m_wa = mrd; m_wd = mdata;
    end else begin
      m_we = 1'b0;
    end
    if (push) begin
      e.rd = mrd; e.d = mdata;
      mq.push_back(e);
    end
    if (mq.size() > max_cnt) max_cnt = mq.size();
    @(posedge clk);
    #1;
    chk("rf_we", 32'(rf_we_o), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr_o), 32'(m_wa));
    chk("rf_wdata", rf_wdata_o, m_wd);
    if (rf_we_o && rf_wdata_o[31:24] == 8'hB0) got_mul.push_back(rf_wdata_o);
    $display("cyc t=%0t av=%0b mv=%0b mrd=%0d -> we=%0b wa=%0d wd=0x%08h cnt=%0d",
             $time, av, mv, mrd, rf_we_o, rf_waddr_o, rf_wdata_o, mul_count_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_order(input string name);
    chk({name, "_len"}, 32'(got_mul.size()), 32'(sent_mul.size()));
    for (int i = 0; i < sent_mul.size() && i < got_mul.size(); i++)
      chk({name, "_data"}, got_mul[i], sent_mul[i]);
  endtask

  task automatic clear_logs();
    sent_mul.delete();
    got_mul.delete();
    seen_not_ready = 1'b0;
    max_cnt = 0;
  endtask

  initial begin
    logic        av_r;
    logic [31:0] ad_r;
    int          k;

    reset = 1'b1;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    mul_valid_i = 1'b0; mul_rd_i = '0; mul_data_i = '0;
    m_we = 1'b0; m_wa = '0; m_wd = '0;
    clear_logs();

    // Directed table: av ard adata mv mrd mdata | we wa wd cnt-after
    vecs[0] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h2A,       1'b1, 5'd7, 32'h2A, 0};
    vecs[1] = '{1'b1, 5'd3, 32'h11,   1'b1, 5'd5, 32'h22,       1'b1, 5'd3, 32'h11, 1};
    vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h22, 0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'h22, 0};
    vecs[4] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd5, 32'h22, 0};
    vecs[5] = '{1'b1, 5'd0, 32'h55,   1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h55, 0};
    vecs[6] = '{1'b1, 5'd9, 32'h99,   1'b1, 5'd0, 32'h77,       1'b1, 5'd9, 32'h99, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_count", 32'(mul_count_o), 32'd0);
    chk("rst_pending", 32'(mul_pending_o), 32'd0);
    chk("rst_ready", 32'(alu_ready_o), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].mv, vecs[i].mrd, vecs[i].mdata);
      chk("vec_we", 32'(rf_we_o), 32'(vecs[i].we));
      chk("vec_waddr", 32'(rf_waddr_o), 32'(vecs[i].wa));
      chk("vec_wdata", rf_wdata_o, vecs[i].wd);
      chk("vec_count", 32'(mul_count_o), 32'(vecs[i].cnt));
    end
    idle(1);

    // Fill to full with a continuous ALU stream, then drain.
    clear_logs();
    k = 0;
    for (int i = 0; i < 14; i++) begin
      step(i < 9, 5'd20, 32'hA000_0000 + 32'(k),
           i < 5, 5'(i + 1), 32'hB000_0001 + 32'(i));
      if (last_accept) k++;
    end
    chk("fill_maxcnt", 32'(max_cnt), 32'd4);
    chk("fill_not_ready", 32'(seen_not_ready), 32'd1);
    check_order("fill_order");

    // Ten multiplier results interleaved with ALU bursts; pointers wrap.
    clear_logs();
    k = 0;
    av_r = 1'b0;
    for (int c = 0; c < 48; c++) begin
      av_r = ((c % 8) < 5 && c < 40) || (av_r && !last_accept && c > 0);
      step(av_r, 5'd21, 32'hA100_0000 + 32'(k),
           (c < 20) && (c % 2 == 0), 5'((c / 2) % 31 + 1), 32'hB000_0100 + 32'(c / 2));
      if (last_accept) k++;
    end
    chk("wrap_sent", 32'(sent_mul.size()), 32'd10);
    check_order("wrap_order");

    // Reset with three entries buffered: they must never be written.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd22, 32'hA200_0000 + 32'(i), 1'b1, 5'(i + 1), 32'hB000_0200 + 32'(i));
    chk("pre_rst_count", 32'(mul_count_o), 32'd3);
    reset = 1'b1;
    alu_valid_i = 1'b1; mul_valid_i = 1'b1; mul_rd_i = 5'd4;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_we = 1'b0; m_wa = '0; m_wd = '0;
    chk("mrst_count", 32'(mul_count_o), 32'd0);
    chk("mrst_we", 32'(rf_we_o), 32'd0);
    chk("mrst_ready", 32'(alu_ready_o), 32'd1);
    chk("mrst_pending", 32'(mul_pending_o), 32'd0);
    clear_logs();
    idle(6);
    chk("mrst_no_write", 32'(got_mul.size()), 32'd0);

    // Randomized traffic; ALU inputs held stable while not accepted.
    av_r = 1'b0;
    ad_r = '0;
    k = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [4:0] ard_n;
      if (!av_r || last_accept) begin
        av_r = ($urandom_range(0, 99) < 50);
        ad_r = {8'hA1, 24'($urandom)};
        k = $urandom_range(0, 31);
      end
      ard_n = 5'(k);
      step(av_r, ard_n, ad_r,
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), {8'hC0, 24'($urandom)});
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
